// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the RAM arbiter: response owner tags and common constants.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    OWNER_NONE  = 2'd0,
    OWNER_FETCH = 2'd1,
    OWNER_DATA  = 2'd2
  } owner_t;

  localparam logic [3:0] BYTE_SELECT_WORD = 4'hF;

  localparam int STREAK_WIDTH = 4;

endpackage

// File: rtl/ram_arbiter_priority.sv
// Grant selection between the fetch and data requesters. Data normally wins,
// but a waiting fetch is guaranteed a slot after MAX_DATA_STREAK data grants.
module ram_arbiter_priority
  import ram_arbiter_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic fetchReq,
  input  logic dataReq,
  output logic fetchGrant,
  output logic dataGrant
);

  localparam logic [STREAK_WIDTH-1:0] STREAK_LIMIT = STREAK_WIDTH'(MAX_DATA_STREAK);

  logic [STREAK_WIDTH-1:0] streak;
  logic                    streakFull;

  assign streakFull = (streak == STREAK_LIMIT);

  // Pick the winner for this cycle; nobody is granted while reset is held.
  always_comb begin
    fetchGrant = 1'b0;
    dataGrant  = 1'b0;
    if (!reset) begin
      if (fetchReq && dataReq) begin
        fetchGrant = streakFull;
        dataGrant  = !streakFull;
      end else begin
        fetchGrant = fetchReq;
        dataGrant  = dataReq;
      end
    end
  end

  // Count consecutive data grants that made a pending fetch wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      streak <= '0;
    end else if (!fetchReq || fetchGrant) begin
      streak <= '0;
    end else if (dataGrant && !streakFull) begin
      streak <= streak + 1'b1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares a single-port word RAM between the instruction fetch port and the
// data port. One RAM operation per cycle; responses return one cycle later,
// tagged to the requester that issued them. Out-of-range accesses are granted
// but never reach the RAM and come back flagged as errors.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int MEMORY_SIZE     = 65536,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetchReq,
  input  logic [DATA_WIDTH-1:0] fetchAddress,
  output logic                  fetchGrant,
  output logic                  fetchValid,
  output logic [DATA_WIDTH-1:0] fetchData,
  output logic                  fetchError,
  input  logic                  dataReq,
  input  logic                  dataStore,
  input  logic [DATA_WIDTH-1:0] dataAddress,
  input  logic [DATA_WIDTH-1:0] dataWriteIn,
  input  logic [3:0]            dataByteSelect,
  output logic                  dataGrant,
  output logic                  dataValid,
  output logic [DATA_WIDTH-1:0] dataReadOut,
  output logic                  dataError,
  output logic [DATA_WIDTH-1:0] ramAddress,
  output logic [DATA_WIDTH-1:0] ramDataWrite,
  output logic [3:0]            ramByteSelect,
  output logic                  ramStore,
  output logic                  ramLoad,
  input  logic [DATA_WIDTH-1:0] ramDataRead
);

  localparam logic [DATA_WIDTH-1:0] MEMORY_LIMIT = DATA_WIDTH'(MEMORY_SIZE);

  logic                  fetchInRange;
  logic                  dataInRange;
  logic [DATA_WIDTH-1:0] lastAddress;
  owner_t                respOwner;
  logic                  respError;
  logic                  respStore;

  assign fetchInRange = (fetchAddress < MEMORY_LIMIT);
  assign dataInRange  = (dataAddress < MEMORY_LIMIT);

  ram_arbiter_priority #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) priorityUnit (
    .clk       (clk),
    .reset     (reset),
    .fetchReq  (fetchReq),
    .dataReq   (dataReq),
    .fetchGrant(fetchGrant),
    .dataGrant (dataGrant)
  );

  // Steer the winner's fields onto the RAM; strobes are suppressed for out-of-range addresses.
  always_comb begin
    ramAddress    = lastAddress;
    ramDataWrite  = '0;
    ramByteSelect = '0;
    ramStore      = 1'b0;
    ramLoad       = 1'b0;
    if (reset) begin
      ramAddress = '0;
    end else if (fetchGrant) begin
      ramAddress    = fetchAddress;
      ramByteSelect = BYTE_SELECT_WORD;
      ramLoad       = fetchInRange;
    end else if (dataGrant) begin
      ramAddress    = dataAddress;
      ramDataWrite  = dataWriteIn;
      ramByteSelect = dataByteSelect;
      ramLoad       = dataInRange && !dataStore;
      ramStore      = dataInRange && dataStore;
    end
  end

  // Remember the last issued address so it stays stable on idle cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      lastAddress <= '0;
    end else if (fetchGrant || dataGrant) begin
      lastAddress <= ramAddress;
    end
  end

  // Record who owns next cycle's response and whether it failed the range check.
  always_ff @(posedge clk) begin
    if (reset) begin
      respOwner <= OWNER_NONE;
      respError <= 1'b0;
      respStore <= 1'b0;
    end else begin
      respOwner <= OWNER_NONE;
      respError <= 1'b0;
      respStore <= 1'b0;
      if (fetchGrant) begin
        respOwner <= OWNER_FETCH;
        respError <= !fetchInRange;
      end else if (dataGrant) begin
        respOwner <= OWNER_DATA;
        respError <= !dataInRange;
        respStore <= dataStore;
      end
    end
  end

  // Route the RAM read word to the owning requester; errors and stores return zero.
  always_comb begin
    fetchValid  = !reset && (respOwner == OWNER_FETCH);
    dataValid   = !reset && (respOwner == OWNER_DATA);
    fetchError  = fetchValid && respError;
    dataError   = dataValid && respError;
    fetchData   = '0;
    dataReadOut = '0;
    if (fetchValid && !respError) begin
      fetchData = ramDataRead;
    end
    if (dataValid && !respError && !respStore) begin
      dataReadOut = ramDataRead;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios followed by random
// traffic, with a scoreboard of expected responses drained by a monitor.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  localparam int DATA_WIDTH      = 32;
  localparam int MEMORY_SIZE     = 65536;
  localparam int MAX_DATA_STREAK = 4;
  localparam int WORDS           = MEMORY_SIZE / 4;

  logic        clk;
  logic        reset;
  logic        fetchReq;
  logic [31:0] fetchAddress;
  logic        fetchGrant;
  logic        fetchValid;
  logic [31:0] fetchData;
  logic        fetchError;
  logic        dataReq;
  logic        dataStore;
  logic [31:0] dataAddress;
  logic [31:0] dataWriteIn;
  logic [3:0]  dataByteSelect;
  logic        dataGrant;
  logic        dataValid;
  logic [31:0] dataReadOut;
  logic        dataError;
  logic [31:0] ramAddress;
  logic [31:0] ramDataWrite;
  logic [3:0]  ramByteSelect;
  logic        ramStore;
  logic        ramLoad;
  logic [31:0] ramDataRead;

  ram_arbiter #(
    .DATA_WIDTH     (DATA_WIDTH),
    .MEMORY_SIZE    (MEMORY_SIZE),
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fetchReq      (fetchReq),
    .fetchAddress  (fetchAddress),
    .fetchGrant    (fetchGrant),
    .fetchValid    (fetchValid),
    .fetchData     (fetchData),
    .fetchError    (fetchError),
    .dataReq       (dataReq),
    .dataStore     (dataStore),
    .dataAddress   (dataAddress),
    .dataWriteIn   (dataWriteIn),
    .dataByteSelect(dataByteSelect),
    .dataGrant     (dataGrant),
    .dataValid     (dataValid),
    .dataReadOut   (dataReadOut),
    .dataError     (dataError),
    .ramAddress    (ramAddress),
    .ramDataWrite  (ramDataWrite),
    .ramByteSelect (ramByteSelect),
    .ramStore      (ramStore),
    .ramLoad       (ramLoad),
    .ramDataRead   (ramDataRead)
  );

  typedef struct {
    bit          isFetch;
    logic [31:0] data;
    bit          err;
  } resp_t;

  resp_t       sb[$];
  logic [31:0] ramMem [WORDS];
  logic [31:0] refMem [WORDS];
  int          checks = 0;
  int          errors = 0;

  // Requester state: each holds its request until granted.
  bit          fPend;
  bit          dPend;
  bit          dStoreP;
  logic [31:0] fAddr;
  logic [31:0] dAddr;
  logic [31:0] dWrite;
  logic [3:0]  dSel;

  // Reference arbitration and address history.
  int          run;
  logic [31:0] lastAddr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM with registered read data.
  always @(posedge clk) begin
    if (ramLoad) ramDataRead <= ramMem[ramAddress[15:2]];
    if (ramStore) begin
      for (int b = 0; b < 4; b++) begin
        if (ramByteSelect[b]) ramMem[ramAddress[15:2]][8*b +: 8] = ramDataWrite[8*b +: 8];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit inRange(input logic [31:0] a);
    return a < 32'(MEMORY_SIZE);
  endfunction

  function automatic logic [31:0] randAddr(input bit aligned);
    logic [31:0] a;
    if ($urandom_range(0, 9) == 0) begin
      case ($urandom_range(0, 3))
        0:       a = 32'(MEMORY_SIZE);
        1:       a = 32'(MEMORY_SIZE) + 32'd4;
        2:       a = 32'hFFFF_FFFC;
        default: a = 32'h8000_0000;
      endcase
    end else begin
      a = 32'($urandom_range(0, 63)) * 32'd4;
      if (!aligned) a = a + 32'($urandom_range(0, 3));
    end
    return a;
  endfunction

  // Drive one cycle of requests, check the grant and RAM side, queue the expected response.
  task automatic applyStimulus(input bit rst);
    bit          expF;
    bit          expD;
    bit          ok;
    logic [31:0] word;
    resp_t       e;
    @(posedge clk);
    #1;
    reset = rst;
    if (rst) begin
      sb.delete();
      lastAddr = 32'h0;
    end
    fetchReq       = fPend;
    fetchAddress   = fAddr;
    dataReq        = dPend;
    dataStore      = dStoreP;
    dataAddress    = dAddr;
    dataWriteIn    = dWrite;
    dataByteSelect = dSel;
    @(negedge clk);
    expF = 1'b0;
    expD = 1'b0;
    if (!rst) begin
      if (fPend && dPend) begin
        if (run >= MAX_DATA_STREAK) expF = 1'b1;
        else expD = 1'b1;
      end else begin
        expF = fPend;
        expD = dPend;
      end
    end
    checkOutput("fetchGrant", fetchGrant, expF);
    checkOutput("dataGrant", dataGrant, expD);
    if (expF) begin
      ok = inRange(fAddr);
      checkOutput("fetchRamAddress", ramAddress, fAddr);
      checkOutput("fetchRamLoad", ramLoad, ok);
      checkOutput("fetchRamStore", ramStore, 1'b0);
      checkOutput("fetchByteSelect", ramByteSelect, 4'hF);
      e.isFetch = 1'b1;
      e.err     = !ok;
      e.data    = ok ? refMem[fAddr[15:2]] : 32'h0;
      sb.push_back(e);
      lastAddr = fAddr;
    end else if (expD) begin
      ok = inRange(dAddr);
      checkOutput("dataRamAddress", ramAddress, dAddr);
      checkOutput("dataRamLoad", ramLoad, ok && !dStoreP);
      checkOutput("dataRamStore", ramStore, ok && dStoreP);
      if (ok && dStoreP) begin
        checkOutput("dataByteSelect", ramByteSelect, dSel);
        word = refMem[dAddr[15:2]];
        for (int b = 0; b < 4; b++) begin
          if (dSel[b]) word[8*b +: 8] = dWrite[8*b +: 8];
        end
        refMem[dAddr[15:2]] = word;
      end
      e.isFetch = 1'b0;
      e.err     = !ok;
      e.data    = (ok && !dStoreP) ? refMem[dAddr[15:2]] : 32'h0;
      sb.push_back(e);
      lastAddr = dAddr;
    end else begin
      checkOutput("idleRamAddress", ramAddress, lastAddr);
      checkOutput("idleRamLoad", ramLoad, 1'b0);
      checkOutput("idleRamStore", ramStore, 1'b0);
    end
    if (rst || !fPend || expF) run = 0;
    else if (expD && run < MAX_DATA_STREAK) run = run + 1;
    if (expF) fPend = 1'b0;
    if (expD) dPend = 1'b0;
  endtask

  // Keep both requesters busy and compare the fetch grant against a fixed pattern.
  task automatic runPattern(input int n, input logic [15:0] fMask, input string tag);
    for (int i = 0; i < n; i++) begin
      fPend   = 1'b1;
      fAddr   = 32'h40;
      dPend   = 1'b1;
      dStoreP = 1'b0;
      dAddr   = 32'h44;
      dWrite  = 32'h0;
      dSel    = 4'h0;
      applyStimulus(1'b0);
      checkOutput(tag, fetchGrant, fMask[i]);
    end
    fPend = 1'b0;
    dPend = 1'b0;
  endtask

  // Monitor: one cycle after every grant the owner must respond; otherwise nothing is valid.
  initial begin
    resp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("fetchValid", fetchValid, e.isFetch);
        checkOutput("dataValid", dataValid, !e.isFetch);
        if (e.isFetch) begin
          checkOutput("fetchData", fetchData, e.data);
          checkOutput("fetchError", fetchError, e.err);
        end else begin
          checkOutput("dataReadOut", dataReadOut, e.data);
          checkOutput("dataError", dataError, e.err);
        end
      end else begin
        checkOutput("quietFetchValid", fetchValid, 1'b0);
        checkOutput("quietDataValid", dataValid, 1'b0);
        checkOutput("quietFetchData", fetchData, 32'h0);
        checkOutput("quietDataReadOut", dataReadOut, 32'h0);
      end
    end
  end

  initial begin
    reset          = 1'b1;
    fetchReq       = 1'b0;
    fetchAddress   = 32'h0;
    dataReq        = 1'b0;
    dataStore      = 1'b0;
    dataAddress    = 32'h0;
    dataWriteIn    = 32'h0;
    dataByteSelect = 4'h0;
    fPend = 1'b0; dPend = 1'b0; dStoreP = 1'b0;
    fAddr = 32'h0; dAddr = 32'h0; dWrite = 32'h0; dSel = 4'h0;
    run = 0;
    lastAddr = 32'h0;
    for (int i = 0; i < WORDS; i++) begin
      ramMem[i] = $urandom;
      refMem[i] = ramMem[i];
    end

    // Reset held with both requesters active, then data wins first.
    fPend = 1'b1; fAddr = 32'h8;
    dPend = 1'b1; dAddr = 32'hC; dStoreP = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1);
    applyStimulus(1'b0);
    checkOutput("firstGrantIsData", dataGrant, 1'b1);
    fPend = 1'b0; dPend = 1'b0;
    applyStimulus(1'b0);

    // Fetch-only read of a known word.
    ramMem[4] = 32'hDEADBEEF;
    refMem[4] = 32'hDEADBEEF;
    fPend = 1'b1; fAddr = 32'h10;
    applyStimulus(1'b0);
    applyStimulus(1'b0);

    // Both requesters saturated: D,D,D,D,F,D,D,D,D,F.
    runPattern(10, 16'h0210, "streakPattern");
    applyStimulus(1'b0);

    // Byte store followed immediately by a load of the same word.
    ramMem[8] = 32'h11223344;
    refMem[8] = 32'h11223344;
    dPend = 1'b1; dStoreP = 1'b1; dAddr = 32'h20; dWrite = 32'h000000AB; dSel = 4'b0001;
    applyStimulus(1'b0);
    dPend = 1'b1; dStoreP = 1'b0; dAddr = 32'h20; dWrite = 32'h0; dSel = 4'h0;
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    checkOutput("storeMergedWord", refMem[8], ramMem[8]);

    // Load just past the end of memory.
    dPend = 1'b1; dStoreP = 1'b0; dAddr = 32'(MEMORY_SIZE);
    applyStimulus(1'b0);
    applyStimulus(1'b0);

    // Reset in the cycle after a fetch grant discards its response.
    fPend = 1'b1; fAddr = 32'h14;
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    applyStimulus(1'b0);

    // A partially built streak is cleared by reset.
    runPattern(3, 16'h0000, "streakBuild");
    fPend = 1'b1; dPend = 1'b1;
    applyStimulus(1'b1);
    runPattern(5, 16'h0010, "streakAfterReset");
    applyStimulus(1'b0);

    // Random traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      if (!fPend && $urandom_range(0, 2) != 0) begin
        fPend = 1'b1;
        fAddr = randAddr(1'b1);
      end
      if (!dPend && $urandom_range(0, 2) != 0) begin
        dPend   = 1'b1;
        dStoreP = 1'($urandom_range(0, 1));
        dAddr   = randAddr(1'b0);
        dWrite  = $urandom;
        dSel    = 4'($urandom_range(0, 15));
      end
      applyStimulus($urandom_range(0, 59) == 0);
    end

    fPend = 1'b0; dPend = 1'b0;
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    @(posedge clk);
    #3;
    checkOutput("scoreboardDrained", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Shares the single-port word RAM between two requesters. Port F is the instruction fetch port, which is read-only and word-sized. Port D is the data port, driven by the memory controller with byte-selected loads and stores. The block sits between the core/memoryController and the RAM. It issues at most one RAM operation per cycle and returns read data one cycle later, tagged to the owning requester. It also blocks out-of-range accesses before they reach the RAM.

Parameters:
DATA_WIDTH, 32, width of addresses and data words
MEMORY_SIZE, 65536, RAM size in bytes; legal addresses are 0..MEMORY_SIZE-1
MAX_DATA_STREAK, 4, maximum consecutive D grants while F is waiting (valid range 1..15)

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
fetchReq  in  1  F requests a word read
fetchAddress  in  DATA_WIDTH  F byte address; must be word-aligned
fetchGrant  out  1  F request accepted this cycle (combinational)
fetchValid  out  1  F read data valid (registered)
fetchData  out  DATA_WIDTH  F read word
fetchError  out  1  with fetchValid: F access was out of range
dataReq  in  1  D requests an operation
dataStore  in  1  D operation is a store (0 = load)
dataAddress  in  DATA_WIDTH  D byte address
dataWriteIn  in  DATA_WIDTH  D store data, already lane-aligned
dataByteSelect  in  4  D byte-lane enables for stores
dataGrant  out  1  D request accepted this cycle (combinational)
dataValid  out  1  D response: read data valid, or store completed (registered)
dataReadOut  out  DATA_WIDTH  D read word; 0 for stores
dataError  out  1  with dataValid: D access was out of range
ramAddress  out  DATA_WIDTH  address to the RAM
ramDataWrite  out  DATA_WIDTH  write data to the RAM
ramByteSelect  out  4  byte enables to the RAM
ramStore  out  1  RAM write strobe
ramLoad  out  1  RAM read strobe
ramDataRead  in  DATA_WIDTH  RAM read data, registered inside the RAM, valid the cycle after ramLoad

Behaviour:
- Reset (sync, high): all grants, RAM strobes, valid and error outputs are 0. Data outputs are 0. The streak counter is 0 and the response owner is NONE.
- Reset mid-operation: any pending response is discarded, so no valid asserts in the cycle after reset.
- A requester holds req and its fields stable until it sees grant. Grant is the acceptance handshake: it occurs in the same cycle as the RAM strobe.
- Arbitration (combinational, no grant while reset):
  - Only one requester active: that requester wins.
  - Both active: D wins, unless streak == MAX_DATA_STREAK, in which case F wins.
- Streak counter:
  - Increments on a D grant while fetchReq=1.
  - Clears on any F grant, or on any cycle with fetchReq=0.
  - Saturates at MAX_DATA_STREAK.
- Issue cycle N, winner address in range:
  - RAM outputs are driven with the winner's fields.
  - F: ramLoad=1, ramByteSelect=4'hF.
  - D: ramLoad=!dataStore, ramStore=dataStore.
- Issue cycle N, address >= MEMORY_SIZE: grant still asserts but both RAM strobes stay 0.
- Response cycle N+1: the owner's valid asserts for exactly one cycle.
  - Load: data = ramDataRead.
  - Error case: error=1 and data=0.
- Pipelined operation: a new grant is allowed every cycle, giving full throughput. Response owner and error flag are held in registers for one cycle.
- Store followed by a load to the same word in the next cycle must return the new data. The RAM writes at the issue edge, so this needs no bypass.
- Idle cycle: RAM strobes are 0 and ramAddress holds its last value. No valid asserts in the following cycle.
- Width rules: addresses are compared unsigned against MEMORY_SIZE as a full DATA_WIDTH value. The streak counter is 4 bits.

Decomposition:
- Shared package holds:
  - Owner enum: OWNER_NONE, OWNER_FETCH, OWNER_DATA.
  - BYTE_SELECT_WORD = 4'hF.
  - Streak counter width constant.
- One sub-module, ram_arbiter_priority, contains the streak counter and the grant select. It takes fetchReq, dataReq, clk and reset, and outputs fetchGrant and dataGrant.
- The top level contains the range check, RAM muxing and response register.

Test Plan:
1. Reset held 3 cycles with both requesters active: all outputs stay 0. First deassert cycle: dataGrant=1; fetchValid and dataValid stay 0 during the reset cycles.
2. Only fetchReq, address 0x10 containing 0xDEADBEEF: fetchGrant and ramLoad in cycle N; cycle N+1 fetchValid=1, fetchData=0xDEADBEEF, fetchError=0.
3. Both requesters continuously active, MAX_DATA_STREAK=4: grant pattern is D,D,D,D,F,D,D,D,D,F. Each grant gets exactly one matching valid one cycle later.
4. D store 0x000000AB with byteSelect 4'b0001 to address 0x20, word previously 0x11223344; next cycle D load of 0x20: dataValid with dataReadOut=0x112233AB.
5. D load of address MEMORY_SIZE (65536): dataGrant=1 with ramLoad=ramStore=0; next cycle dataValid=1, dataError=1, dataReadOut=0.
6. Reset asserted in the cycle after an F grant: fetchValid stays 0 and the streak counter reads 0 afterwards.
